// File: rtl/memory_unit_pkg.sv
// Shared definitions for the MemoryUnit write arbiter.
//   MEM_WIDTH : width of the MemoryUnit data register
//   state_t   : arbiter FSM states
//   clog2     : index/counter width helper (never returns less than 1)
package memory_unit_pkg;

    localparam int MEM_WIDTH = 35;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Ceiling log2, floored at 1 so that a value of 1 still yields a
    // usable one-bit vector (e.g. a retry counter with no retries).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/memory_unit_arbiter_rr_pick.sv
// Rotating-priority selector.
//   req_valid  : request vector
//   last_grant : index granted most recently; search starts just above it
//   sel        : first valid index found searching upward with wrap
//   any        : at least one request is valid (sel meaningful only then)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [IDW-1:0]  sel,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        // i runs 1..NREQ so the previous winner is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(last_grant) + i) % NREQ);
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/memory_unit_arbiter.sv
// Round-robin write controller in front of the MemoryUnit register.
// Accepts one request, writes it for one cycle, verifies the read-back and
// rewrites up to MAX_RETRY times before reporting failure.
//   clk, arst   : clock, synchronous active-high reset
//   req_valid   : per-requester request; req_data packs WIDTH bits each
//   req_ready   : one-hot acceptance pulse (data captured that cycle)
//   mem_wren    : memory write enable, mem_din: memory write data
//   mem_dout    : memory read-back
//   done / fail : verify-ok / retry-exhausted pulses, done_id = requester
//   busy        : not IDLE, err_sticky : any fail since reset
import memory_unit_pkg::*;

module memory_unit_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = MEM_WIDTH,
    parameter int MAX_RETRY = 2
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    mem_wren,
    output logic [WIDTH-1:0]        mem_din,
    input  logic [WIDTH-1:0]        mem_dout,
    output logic                    done,
    output logic                    fail,
    output logic [clog2(NREQ)-1:0]  done_id,
    output logic                    busy,
    output logic                    err_sticky
);

    localparam int IDW = clog2(NREQ);
    localparam int RW  = clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t          state, state_nx;
    logic [WIDTH-1:0] data_q;
    logic [RW-1:0]   retry_cnt;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  sel;
    logic            any;
    logic            grant;
    logic            match;
    logic            can_retry;
    logic            err_q;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .sel        (sel),
        .any        (any)
    );

    assign match     = (mem_dout == data_q);
    assign can_retry = (retry_cnt < RETRY_MAX);

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        done     = 1'b0;
        fail     = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    grant    = 1'b1;
                    state_nx = WRITE;
                end
            end
            WRITE: state_nx = CHECK;
            CHECK: begin
                if (match) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (can_retry) begin
                    state_nx = WRITE;
                end else begin
                    fail     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Outputs are forced quiet during reset regardless of the
        // (possibly stale) state register.
        if (arst) begin
            grant = 1'b0;
            done  = 1'b0;
            fail  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= IDLE;
            data_q     <= '0;
            retry_cnt  <= '0;
            last_grant <= IDW'(NREQ - 1);
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                data_q     <= req_data[int'(sel)*WIDTH +: WIDTH];
                last_grant <= sel;
                retry_cnt  <= '0;
            end else if (state == CHECK && !match && can_retry) begin
                retry_cnt  <= retry_cnt + RW'(1);
            end
            if (fail) err_q <= 1'b1;
        end
    end

    assign req_ready  = grant ? (NREQ'(1) << sel) : '0;
    assign mem_wren   = (state == WRITE) && !arst;
    assign mem_din    = arst ? '0 : data_q;
    assign busy       = (state != IDLE) && !arst;
    assign done_id    = (done || fail) ? last_grant : '0;
    assign err_sticky = err_q && !arst;

endmodule

// File: tb/tb_memory_unit_arbiter.sv
// Bench for memory_unit_arbiter with a behavioural MemoryUnit register.
module tb_memory_unit_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 35;

    localparam logic [W-1:0] D0 = 35'h00FE03F80;
    localparam logic [W-1:0] D1 = 35'h123456789;
    localparam logic [W-1:0] D2 = 35'h2AAAA5555;
    localparam logic [W-1:0] D3 = 35'h70F0F0F0F;
    localparam logic [W-1:0] DR = 35'h000003F80;

    logic            clk = 1'b0;
    logic            arst;
    logic [NREQ-1:0] req_valid;
    logic [W-1:0]    data [NREQ];
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic            mem_wren;
    logic [W-1:0]    mem_din;
    logic [W-1:0]    mem_dout;
    logic            done;
    logic            fail;
    logic [1:0]      done_id;
    logic            busy;
    logic            err_sticky;

    logic [W-1:0]    memq = '0;
    logic            stuck;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign req_data = {data[3], data[2], data[1], data[0]};

    always @(posedge clk) if (mem_wren) memq <= mem_din;
    assign mem_dout = stuck ? '0 : memq;

    memory_unit_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (W),
        .MAX_RETRY (2)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .mem_wren   (mem_wren),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .done       (done),
        .fail       (fail),
        .done_id    (done_id),
        .busy       (busy),
        .err_sticky (err_sticky)
    );

    typedef struct {
        logic         a;
        logic [3:0]   v;
        logic [3:0]   r;
        logic         w;
        logic [W-1:0] d;
        logic         dn;
        logic [1:0]   id;
        logic         b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic a, logic [3:0] v, logic [3:0] r, logic w,
                                logic [W-1:0] d, logic dn, logic [1:0] id, logic b);
        vec_t x;
        x.a = a; x.v = v; x.r = r; x.w = w; x.d = d; x.dn = dn; x.id = id; x.b = b;
        return x;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_cycle(string tag, logic [3:0] r, logic w, logic [W-1:0] d,
                                logic dn, logic fl, logic b, logic [1:0] id, logic e);
        chk({tag, " req_ready"},  64'(req_ready),  64'(r));
        chk({tag, " mem_wren"},   64'(mem_wren),   64'(w));
        chk({tag, " mem_din"},    64'(mem_din),    64'(d));
        chk({tag, " done"},       64'(done),       64'(dn));
        chk({tag, " fail"},       64'(fail),       64'(fl));
        chk({tag, " busy"},       64'(busy),       64'(b));
        chk({tag, " done_id"},    64'(done_id),    64'(id));
        chk({tag, " err_sticky"}, 64'(err_sticky), 64'(e));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst      = 1'b1;
        req_valid = 4'b1111;
        stuck     = 1'b0;
        data[0] = D0; data[1] = D1; data[2] = D2; data[3] = D3;

        // reset with all requesters active
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, '0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, '0, 0, 0, 0));
        // fairness 0,1,2,3,0 with continuous requests
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 0, '0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, D0, 0, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, D0, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0010, 0, D0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, D1, 0, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, D1, 1, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 0, D1, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, D2, 0, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, D2, 1, 2, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b1000, 0, D2, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, D3, 0, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, D3, 1, 3, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 0, D3, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 1, D0, 0, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, D0, 1, 0, 1));
        // no requests: stays idle
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, D0, 0, 0, 0));
        // priority resume
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, D0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, D1, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, D1, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0110, 4'b0100, 0, D1, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 1, D2, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0110, 4'b0000, 0, D2, 1, 2, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, D2, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, D1, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, D1, 1, 1, 1));

        foreach (tbl[i]) begin
            step();
            arst      = tbl[i].a;
            req_valid = tbl[i].v;
            #1;
            expect_cycle($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].d,
                         tbl[i].dn, 1'b0, tbl[i].b, tbl[i].id, 1'b0);
        end

        // retry/fail: read-back stuck at zero, three writes then fail
        step(); data[0] = DR; stuck = 1'b1; req_valid = 4'b0001; #1;
        expect_cycle("rty accept", 4'b0001, 0, D1, 0, 0, 0, 0, 0);
        step(); req_valid = 4'b0000; #1;
        expect_cycle("rty wr1", 4'b0000, 1, DR, 0, 0, 1, 0, 0);
        step(); #1;
        expect_cycle("rty chk1", 4'b0000, 0, DR, 0, 0, 1, 0, 0);
        step(); #1;
        expect_cycle("rty wr2", 4'b0000, 1, DR, 0, 0, 1, 0, 0);
        step(); #1;
        expect_cycle("rty chk2", 4'b0000, 0, DR, 0, 0, 1, 0, 0);
        step(); #1;
        expect_cycle("rty wr3", 4'b0000, 1, DR, 0, 0, 1, 0, 0);
        step(); #1;
        expect_cycle("rty fail", 4'b0000, 0, DR, 0, 1, 1, 0, 0);
        // following good write: done, sticky error persists
        step(); stuck = 1'b0; req_valid = 4'b0001; #1;
        expect_cycle("good accept", 4'b0001, 0, DR, 0, 0, 0, 0, 1);
        step(); req_valid = 4'b0000; #1;
        expect_cycle("good wr", 4'b0000, 1, DR, 0, 0, 1, 0, 1);
        step(); #1;
        expect_cycle("good done", 4'b0000, 0, DR, 1, 0, 1, 0, 1);

        // reset asserted during WRITE aborts the write silently
        step(); req_valid = 4'b0100; #1;
        expect_cycle("mid accept", 4'b0100, 0, DR, 0, 0, 0, 0, 1);
        step(); #1;
        expect_cycle("mid wr", 4'b0000, 1, D2, 0, 0, 1, 0, 1);
        arst = 1'b1;
        step(); arst = 1'b0; #1;
        expect_cycle("mid after rst", 4'b0100, 0, '0, 0, 0, 0, 0, 0);
        step(); req_valid = 4'b0000; #1;
        expect_cycle("mid rewr", 4'b0000, 1, D2, 0, 0, 1, 0, 0);
        step(); #1;
        expect_cycle("mid done", 4'b0000, 0, D2, 1, 0, 1, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
